din_debounce_sync: RTL and testbench

//   Conditions a raw asynchronous 1-bit input (button, strap, external level) into a clean

---
 rtl/din_debounce_sync_if.sv | 32 +++
 rtl/din_debounce_sync.sv | 161 ++++++++++++++++
 tb/tb_din_debounce_sync.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/din_debounce_sync_if.sv
// din_debounce_sync_if
//   Groups the conditioned-input signals of din_debounce_sync.
//   din  : raw asynchronous level from the outside world
//   dout : debounced, clock-domain level
//   rise : one-cycle pulse when dout goes 0->1
//   fall : one-cycle pulse when dout goes 1->0
//   busy : a candidate level change is being qualified
//   Modports: slave  = the conditioner (consumes din, produces the rest)
//             master = the user of the conditioner (drives din, observes the rest)
interface din_debounce_sync_if;
  logic din;
  logic dout;
  logic rise;
  logic fall;
  logic busy;

  modport slave (
    input  din,
    output dout,
    output rise,
    output fall,
    output busy
  );

  modport master (
    output din,
    input  dout,
    input  rise,
    input  fall,
    input  busy
  );
endinterface

// File: rtl/din_debounce_sync.sv
// din_debounce_sync
//   Turns a raw asynchronous 1-bit input into a clean level in the clk domain:
//   a flip-flop synchronizer chain, a consecutive-cycle debounce counter and
//   single-cycle rise/fall pulses on every accepted level change.
//   Ports:
//     clk      : rising-edge clock
//     reset_n  : asynchronous active-low reset
//     io.din   : raw asynchronous input
//     io.dout  : debounced level (registered)
//     io.rise  : one-cycle pulse, dout went 0->1 on this edge
//     io.fall  : one-cycle pulse, dout went 1->0 on this edge
//     io.busy  : high while a candidate change is being qualified
module din_debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter bit RESET_VAL       = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  din_debounce_sync_if.slave   io
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  state_t                 state_q, state_d;
  logic                   dout_q, dout_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;
  logic                   ds;

  // Synchronizer chain: stage 0 captures the raw input, each later stage
  // copies the one before it.
  assign sync_d[0] = io.din;
  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
    assign sync_d[gi] = sync_q[gi-1];
  end

  // Only the last synchronizer stage is allowed to feed the debounce logic.
  assign ds = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    busy_d  = busy_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      STABLE_LO: begin
        cnt_d = '0;
        if (ds) begin
          if (DEBOUNCE_CYCLES == 1) begin
            // A single matching cycle is enough: accept on the spot.
            state_d = STABLE_HI;
            dout_d  = 1'b1;
            rise_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = WAIT_HI;
            cnt_d   = CNT_ONE;
            busy_d  = 1'b1;
          end
        end
      end

      WAIT_HI: begin
        if (!ds) begin
          // Bounced back: drop the candidate, qualification restarts at 1.
          state_d = STABLE_LO;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STABLE_HI: begin
        cnt_d = '0;
        if (!ds) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = STABLE_LO;
            dout_d  = 1'b0;
            fall_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = WAIT_LO;
            cnt_d   = CNT_ONE;
            busy_d  = 1'b1;
          end
        end
      end

      WAIT_LO: begin
        if (ds) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = RESET_VAL ? STABLE_HI : STABLE_LO;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= {SYNC_STAGES{RESET_VAL}};
      cnt_q   <= '0;
      state_q <= RESET_VAL ? STABLE_HI : STABLE_LO;
      dout_q  <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign io.dout = dout_q;
  assign io.rise = rise_q;
  assign io.fall = fall_q;
  assign io.busy = busy_q;

endmodule

// File: tb/tb_din_debounce_sync.sv
// tb_din_debounce_sync
//   Scoreboard bench for din_debounce_sync. A reference model follows the
//   input through an ideal delay line and a run-length rule ("accept a new
//   level after DEB consecutive sampled cycles of it") and queues the pulses
//   it expects; a negedge monitor compares the DUT's pulses, level and busy.
module tb_din_debounce_sync;

  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam bit RV   = 1'b0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  din_debounce_sync_if io();

  din_debounce_sync #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .RESET_VAL      (RV)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .io     (io.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit lvl;
  } pulse_t;

  pulse_t exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     n_pulses = 0;

  // ---------------- reference model ----------------
  int cyc = 0;            // edges seen since time zero
  bit m_dline[$];         // ideal SYNC-edge delay of din
  int m_run  = 0;         // consecutive sampled cycles disagreeing with m_dout
  bit m_dout = RV;
  bit m_busy = 1'b0;

  task automatic model_reset();
    m_dline.delete();
    for (int i = 0; i < SYNC; i++) m_dline.push_back(RV);
    m_run  = 0;
    m_dout = RV;
    m_busy = 1'b0;
    exp_q.delete();
  endtask

  initial model_reset();

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      bit seen;
      cyc++;
      seen = m_dline.pop_front();
      m_dline.push_back(io.din);
      if (seen != m_dout) m_run++;
      else m_run = 0;
      if (m_run == DEB) begin
        pulse_t p;
        m_dout = ~m_dout;
        m_run  = 0;
        p.cyc  = cyc;
        p.lvl  = m_dout;
        exp_q.push_back(p);
      end
      m_busy = (m_run != 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic prev_dout = RV;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_dout = RV;
    end else begin
      bit pulse, want;
      pulse = io.rise | io.fall;
      want  = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc);
      check("rise_and_fall_exclusive", {31'd0, io.rise & io.fall}, 32'd0);
      check("dout_level", {31'd0, io.dout}, {31'd0, m_dout});
      check("busy_level", {31'd0, io.busy}, {31'd0, m_busy});
      if (io.dout !== prev_dout)
        check("dout_change_has_pulse", {31'd0, pulse}, 32'd1);
      prev_dout = io.dout;
      if (pulse || want) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          pulse_t p;
          p = exp_q.pop_front();
          check("pulse_present", {31'd0, pulse}, 32'd1);
          check("pulse_edge", cyc, p.cyc);
          check("pulse_is_rise", {31'd0, io.rise}, {31'd0, p.lvl});
          check("pulse_is_fall", {31'd0, io.fall}, {31'd0, ~p.lvl});
          n_pulses++;
          $display("edge %0d: %s observed, expected %s at edge %0d",
                   cyc, io.rise ? "rise" : (io.fall ? "fall" : "none"),
                   p.lvl ? "rise" : "fall", p.cyc);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold(input bit v, input int n);
    io.din = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int pulses_before;
    io.din  = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dout", {31'd0, io.dout}, {31'd0, RV});
    check("reset_busy", {31'd0, io.busy}, 32'd0);
    check("reset_rise", {31'd0, io.rise}, 32'd0);
    check("reset_fall", {31'd0, io.fall}, 32'd0);
    reset_n = 1'b1;

    // Quiet input after reset.
    hold(1'b0, 20);
    check("quiet_no_pulse", n_pulses, 0);

    // Clean rise, then clean fall.
    pulses_before = n_pulses;
    hold(1'b1, 15);
    check("clean_rise_count", n_pulses - pulses_before, 1);
    check("clean_rise_dout", {31'd0, io.dout}, 32'd1);
    pulses_before = n_pulses;
    hold(1'b0, 15);
    check("clean_fall_count", n_pulses - pulses_before, 1);
    check("clean_fall_dout", {31'd0, io.dout}, 32'd0);

    // Short glitch: never accepted.
    pulses_before = n_pulses;
    hold(1'b1, 5);
    hold(1'b0, 12);
    check("glitch_no_pulse", n_pulses - pulses_before, 0);
    check("glitch_busy_cleared", {31'd0, io.busy}, 32'd0);

    // Bounce every 3 cycles, then settle high: exactly one rise.
    pulses_before = n_pulses;
    for (int i = 0; i < 40 / 3; i++) hold(i[0], 3);
    hold(1'b1, 15);
    check("bounce_one_rise", n_pulses - pulses_before, 1);

    // Fall back low, then reset in the middle of qualifying a rise.
    hold(1'b0, 15);
    hold(1'b1, 6);
    check("busy_before_reset", {31'd0, io.busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_dout", {31'd0, io.dout}, 32'd0);
    check("async_reset_busy", {31'd0, io.busy}, 32'd0);
    check("async_reset_rise", {31'd0, io.rise}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    pulses_before = n_pulses;
    hold(1'b1, 15);
    check("post_reset_rise", n_pulses - pulses_before, 1);

    // Randomized bursts with random hold lengths around the debounce window.
    for (int i = 0; i < 60; i++) begin
      hold(1'($urandom), $urandom_range(1, 2 * DEB));
    end
    hold(1'b0, 20);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
